// File: rtl/ram_pkg.sv
// ram_pkg: shared state type and depth derivation for the clearable RAM tile
package ram_pkg;
   typedef enum logic {CLEAR, READY} state_e;
   function automatic int unsigned depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction
endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: sweep sequencer that zeroes every word after reset or on clear
// Ports: clk, rst_n (async, active-low), clear (sweep request),
//        sweep_we/sweep_addr (zero-write port into the array), busy (sweep active)
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr,
   output logic              busy
);
   // DEPTH-1 is all ones; explicit terminal compare avoids relying on wrap
   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      if (state_q == CLEAR) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
         if (ptr_q == LAST) begin
            state_d = READY;
            busy_d  = 1'b0;
         end
      end else if (clear) begin
         state_d = CLEAR;
         ptr_d   = '0;
         busy_d  = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end
   assign sweep_we   = (state_q == CLEAR);
   assign sweep_addr = ptr_q;
   assign busy       = busy_q;
endmodule

// File: rtl/ram_sync_clear.sv
// ram_sync_clear: 1R1W RAM with registered write-first reads and hardware clear
// Ports: clk, rst_n (async, active-low), en (chip select), read/raddr,
//        write/waddr/wdata, clear (zero request), rdata/rvalid (1-cycle read),
//        busy (sweep in progress, requests ignored)
module ram_sync_clear
   import ram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clear,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy
);
   localparam int DEPTH = int'(depth(ADDR_W));
   logic [DATA_W-1:0] mem [DEPTH];
   logic              sweep_we, user_we, user_re, we;
   logic [ADDR_W-1:0] sweep_addr, wa;
   logic [DATA_W-1:0] wd, rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   ram_clear_fsm #(.ADDR_W(ADDR_W)) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr),
      .busy       (busy)
   );
   // sweep owns the write port while busy; user requests are dropped then
   assign user_we  = !busy && en && write;
   assign user_re  = !busy && en && read;
   assign we       = sweep_we || user_we;
   assign wa       = sweep_we ? sweep_addr : waddr;
   assign wd       = sweep_we ? '0 : wdata;
   // write-first: a same-address write this cycle wins over the stored word
   assign rdata_d  = !user_re ? rdata_q : (user_we && waddr == raddr) ? wdata : mem[raddr];
   assign rvalid_d = user_re;
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
endmodule

// File: tb/tb_ram_sync_clear.sv
// tb_ram_sync_clear: self-checking bench for ram_sync_clear (16x16 and 64x32 instances)
module tb_ram_sync_clear;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic        a_rst_n = 1'b0, a_en = 1'b0, a_read = 1'b0, a_write = 1'b0, a_clear = 1'b0;
   logic [3:0]  a_raddr = '0, a_waddr = '0;
   logic [15:0] a_wdata = '0, a_rdata;
   logic        a_rvalid, a_busy;

   logic        b_rst_n = 1'b0, b_en = 1'b0, b_read = 1'b0, b_write = 1'b0, b_clear = 1'b0;
   logic [5:0]  b_raddr = '0, b_waddr = '0;
   logic [31:0] b_wdata = '0, b_rdata;
   logic        b_rvalid, b_busy;

   logic [15:0] ma [16];
   logic [31:0] mb [64];

   ram_sync_clear #(.DATA_W(16), .ADDR_W(4)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .en(a_en), .read(a_read), .write(a_write),
      .raddr(a_raddr), .waddr(a_waddr), .wdata(a_wdata), .clear(a_clear),
      .rdata(a_rdata), .rvalid(a_rvalid), .busy(a_busy)
   );

   ram_sync_clear #(.DATA_W(32), .ADDR_W(6)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .en(b_en), .read(b_read), .write(b_write),
      .raddr(b_raddr), .waddr(b_waddr), .wdata(b_wdata), .clear(b_clear),
      .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_en = 1'b0; a_read = 1'b0; a_write = 1'b0; a_clear = 1'b0;
   endtask

   task automatic count_busy(input string name, input int expect_n);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (a_busy && n < 200);
      tests++;
      if (n !== expect_n || a_busy !== 1'b0) begin
         fails++;
         $display("FAIL %s: busy cycles=%0d busy=%b, required %0d and 0", name, n, a_busy, expect_n);
      end
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < 16; i++) begin
         a_en = 1'b1; a_read = 1'b1; a_raddr = 4'(i);
         cyc();
         tests++;
         if (a_rdata !== 16'h0 || a_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL %s @%0d: rdata=%h rvalid=%b, required 0000 1", name, i, a_rdata, a_rvalid);
         end
      end
      a_idle();
   endtask

   task automatic test_reset();
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      #12;
      tests++;
      if (a_busy !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 16'h0) begin
         fails++;
         $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, required 1 0 0000", a_busy, a_rvalid, a_rdata);
      end
      cyc();
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      count_busy("reset_sweep", 16);
      for (int i = 0; i < 16; i++) ma[i] = '0;
      for (int i = 0; i < 64; i++) mb[i] = '0;
      read_all_zero("reset_read_zero");
      cyc();
      tests++;
      if (a_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL reset_rvalid_drop: rvalid=%b, required 0", a_rvalid);
      end
   endtask

   task automatic test_write_read();
      a_en = 1'b1; a_write = 1'b1; a_waddr = 4'd3; a_wdata = 16'hBEEF;
      cyc();
      ma[3] = 16'hBEEF;
      a_write = 1'b0; a_read = 1'b1; a_raddr = 4'd3;
      cyc();
      tests++;
      if (a_rdata !== 16'hBEEF || a_rvalid !== 1'b1) begin
         fails++;
         $display("FAIL write_read: rdata=%h rvalid=%b, required beef 1", a_rdata, a_rvalid);
      end
      a_idle();
      cyc();
      tests++;
      if (a_rdata !== 16'hBEEF || a_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL read_hold: rdata=%h rvalid=%b, required beef 0", a_rdata, a_rvalid);
      end
   endtask

   task automatic test_forward();
      a_en = 1'b1; a_write = 1'b1; a_waddr = 4'd7; a_wdata = 16'h7777;
      cyc();
      ma[7] = 16'h7777;
      a_read = 1'b1; a_raddr = 4'd5; a_waddr = 4'd5; a_wdata = 16'h1234;
      cyc();
      ma[5] = 16'h1234;
      tests++;
      if (a_rdata !== 16'h1234 || a_rvalid !== 1'b1) begin
         fails++;
         $display("FAIL forward_same: rdata=%h rvalid=%b, required 1234 1", a_rdata, a_rvalid);
      end
      a_raddr = 4'd7; a_waddr = 4'd6; a_wdata = 16'h6666;
      cyc();
      tests++;
      if (a_rdata !== ma[7] || a_rvalid !== 1'b1) begin
         fails++;
         $display("FAIL forward_diff: rdata=%h rvalid=%b, required %h 1", a_rdata, a_rvalid, ma[7]);
      end
      ma[6] = 16'h6666;
      a_idle();
      a_en = 1'b1; a_read = 1'b1; a_raddr = 4'd6;
      cyc();
      tests++;
      if (a_rdata !== 16'h6666) begin
         fails++;
         $display("FAIL forward_diff_write: rdata=%h, required 6666", a_rdata);
      end
      a_idle();
   endtask

   task automatic test_clear();
      for (int i = 0; i < 16; i++) begin
         a_en = 1'b1; a_write = 1'b1; a_waddr = 4'(i);
         a_wdata = 16'($urandom_range(1, 16'hFFFF));
         ma[i] = a_wdata;
         cyc();
      end
      a_idle();
      a_en = 1'b1; a_read = 1'b1; a_raddr = 4'd9;
      cyc();
      tests++;
      if (a_rdata !== ma[9] || a_rdata === 16'h0) begin
         fails++;
         $display("FAIL fill_check: rdata=%h, required %h", a_rdata, ma[9]);
      end
      a_en = 1'b1; a_clear = 1'b1; a_write = 1'b1; a_waddr = 4'd2; a_wdata = 16'hAAAA;
      a_read = 1'b1; a_raddr = 4'd2;
      cyc();
      tests++;
      if (a_rdata !== 16'hAAAA || a_rvalid !== 1'b1 || a_busy !== 1'b1) begin
         fails++;
         $display("FAIL clear_edge: rdata=%h rvalid=%b busy=%b, required aaaa 1 1", a_rdata, a_rvalid, a_busy);
      end
      a_clear = 1'b0;
      begin
         int n = 0;
         int bad = 0;
         do begin
            a_raddr = 4'($urandom_range(0, 15));
            a_waddr = 4'($urandom_range(0, 15));
            a_wdata = 16'($urandom_range(1, 16'hFFFF));
            cyc();
            n++;
            if (a_rvalid !== 1'b0 || a_rdata !== 16'hAAAA) bad++;
         end while (a_busy && n < 200);
         tests++;
         if (n !== 16 || bad !== 0) begin
            fails++;
            $display("FAIL clear_sweep: busy cycles=%0d ignored-violations=%0d, required 16 0", n, bad);
         end
      end
      a_idle();
      for (int i = 0; i < 16; i++) ma[i] = '0;
      read_all_zero("clear_read_zero");
   endtask

   task automatic test_reset_mid();
      a_en = 1'b1; a_write = 1'b1; a_waddr = 4'd4; a_wdata = 16'h5A5A;
      cyc();
      a_write = 1'b0; a_read = 1'b1; a_raddr = 4'd4;
      cyc();
      a_idle();
      a_clear = 1'b1;
      cyc();
      a_clear = 1'b0;
      repeat (8) cyc();
      tests++;
      if (a_rdata !== 16'h5A5A || a_busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: rdata=%h busy=%b, required 5a5a 1", a_rdata, a_busy);
      end
      a_rst_n = 1'b0;
      #1;
      tests++;
      if (a_rdata !== 16'h0 || a_rvalid !== 1'b0 || a_busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset: rdata=%h rvalid=%b busy=%b, required 0000 0 1", a_rdata, a_rvalid, a_busy);
      end
      cyc();
      a_rst_n = 1'b1;
      count_busy("mid_reset_sweep", 16);
      for (int i = 0; i < 16; i++) ma[i] = '0;
      read_all_zero("mid_reset_zero");
   endtask

   task automatic test_en_low();
      a_en = 1'b0; a_read = 1'b1; a_write = 1'b1; a_waddr = 4'd1; a_raddr = 4'd1; a_wdata = 16'hFFFF;
      cyc();
      tests++;
      if (a_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL en_low_rvalid: rvalid=%b, required 0", a_rvalid);
      end
      a_idle();
      a_en = 1'b1; a_read = 1'b1; a_raddr = 4'd1;
      cyc();
      tests++;
      if (a_rdata !== ma[1] || a_rvalid !== 1'b1) begin
         fails++;
         $display("FAIL en_low_mem: rdata=%h rvalid=%b, required %h 1", a_rdata, a_rvalid, ma[1]);
      end
      a_idle();
   endtask

   task automatic test_random_b();
      int n = 0;
      int bad = 0;
      logic [31:0] exp_d = b_rdata;
      logic        exp_v;
      while (b_busy && n < 200) begin
         cyc();
         n++;
      end
      tests++;
      if (b_busy !== 1'b0) begin
         fails++;
         $display("FAIL b_ready: busy=%b after %0d cycles, required 0", b_busy, n);
      end
      for (int k = 0; k < 400; k++) begin
         b_en    = ($urandom_range(0, 7) != 0);
         b_read  = $urandom_range(0, 1) == 1;
         b_write = $urandom_range(0, 1) == 1;
         b_raddr = 6'($urandom_range(0, 15) + (k < 200 ? 0 : 48));
         b_waddr = 6'($urandom_range(0, 15) + (k < 200 ? 0 : 48));
         b_wdata = $urandom();
         exp_v = b_en && b_read;
         if (exp_v) exp_d = (b_en && b_write && b_waddr == b_raddr) ? b_wdata : mb[b_raddr];
         cyc();
         if (b_en && b_write) mb[b_waddr] = b_wdata;
         tests++;
         if (b_rdata !== exp_d || b_rvalid !== exp_v) begin
            fails++;
            bad++;
            if (bad < 10)
               $display("FAIL b_random[%0d]: rdata=%h rvalid=%b, required %h %b", k, b_rdata, b_rvalid, exp_d, exp_v);
         end
      end
      b_en = 1'b0; b_read = 1'b0; b_write = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_forward();
      test_clear();
      test_reset_mid();
      test_en_low();
      test_random_b();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ram_sync_clear.md
# ram_sync_clear

Parametrised single-clock 1R1W word RAM with registered read data, write-first forwarding, and a hardware clear sequencer. It succeeds the fixed 16-bit, 4096-word hierarchical RAM. Width and depth are generic, reads have a defined one-cycle latency with a valid strobe, and every word is zeroed automatically after reset or on request. It serves as the data/instruction memory tile for the CPU datapath.

## Interface
- DATA_W, 16, word width in bits (≥1)
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words (ADDR_W ≥1)
- clk  in  1  sole clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  chip select; read/write ignored when low
- read  in  1  read request (qualified by en)
- write  in  1  write request (qualified by en)
- raddr  in  ADDR_W  read address
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- clear  in  1  request full-memory zeroing (pulse or level)
- rdata  out  DATA_W  registered read data
- rvalid  out  1  rdata updated this cycle
- busy  out  1  clear sweep in progress; requests ignored

## Operation
- States: CLEAR, READY.
- Reset (rst_n low): state=CLEAR, sweep pointer=0, rdata=0, rvalid=0, busy=1. Array contents are not touched by reset itself.
- CLEAR, each cycle: write 0 to mem[ptr] and increment ptr. On the edge where ptr == DEPTH-1: that word is written, state→READY, busy→0 on the following cycle. The sweep takes exactly DEPTH cycles.
- In CLEAR: read, write and clear are ignored. rvalid=0. rdata holds its value.
- READY, write: en&write → mem[waddr]=wdata at the edge.
- READY, read: en&read → rdata=mem[raddr] at the edge; rvalid=1 for that cycle only. Otherwise rvalid=0 and rdata holds.
- Same-cycle read and write to the same address: rdata = wdata (write-first). Different addresses are independent.
- READY, clear=1 at an edge: that cycle's read/write are still performed. state→CLEAR, ptr→0, busy=1 from the next cycle. A clear held high during a sweep has no further effect. If clear is still high when the sweep finishes, a new sweep starts immediately after READY is entered for one cycle.
- rst_n asserted mid-sweep: the sweep restarts from 0 on release.
- Address arithmetic: ptr is ADDR_W+1 bits or uses an explicit terminal compare. No silent wrap past DEPTH-1.

## Timing
- Read latency: 1 cycle (request at edge k → rdata/rvalid valid after edge k).
- Write visible to a read at the same edge (forwarded) and to all later reads.
- Post-reset: busy high for DEPTH cycles after the first edge with rst_n high. The first accepted request is at edge DEPTH+1.
- Clear latency: busy rises one cycle after clear is sampled, and stays high DEPTH cycles.
- Throughput: one read and one write per cycle in READY.

## Structure
- Package ram_pkg: state enum (CLEAR, READY) and the helper DEPTH function/localparam derivation.
- Sub-module ram_clear_fsm: owns the state, ptr and busy. It outputs the sweep write enable and address to the main array mux.
- Top ram_sync_clear: storage array, write-port mux (sweep vs user), read register and forwarding compare.

## Test plan
- Reset then idle, DATA_W=16, ADDR_W=4 → busy=1 for exactly 16 cycles. After that, reading all addresses returns 0 with rvalid=1 one cycle after each request.
- Write 0xBEEF @3, then read @3 the next cycle → rdata=0xBEEF, rvalid=1 for one cycle. rdata then holds with rvalid=0.
- Same-cycle write 0x1234 @5 and read @5 → rdata=0x1234 (forwarded). Same-cycle write @6 and read @7 → old mem[7].
- Fill the memory with non-zero values, then pulse clear together with a write 0xAAAA @2 → busy high 16 cycles. Requests during the sweep are ignored (rvalid=0). All reads afterwards return 0, including @2.
- Assert rst_n low at sweep cycle 8 → rdata=0, rvalid=0 immediately. After release, busy is high for a full 16 cycles.
- en=0 with read=write=1 → no rvalid, memory unchanged. Check DATA_W=32, ADDR_W=6 with a random read/write against a reference model.
